// File: rtl/hier_seq_pkg.sv
// rtl/hier_seq_pkg.sv - shared state/mode enums and lowest-zero helper for the child sequencer
package hier_seq_pkg;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DONE, ERR} state_e;
  typedef enum logic {MODE_PAR, MODE_SEQ} mode_e;

  localparam int MAX_CHILDREN = 32;

  function automatic logic [4:0] lowest_zero(input logic [MAX_CHILDREN-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_CHILDREN - 1; i >= 0; i--) begin
      if (!v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hier_timeout_counter.sv
// rtl/hier_timeout_counter.sv - saturating phase counter; expired when the post-increment value reaches a nonzero limit
module hier_timeout_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limit_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // The current WAIT cycle counts toward the limit, so compare the incremented value.
  assign expired_o = en_i && !clr_i && (limit_i != '0) && (cnt_d >= limit_i);

endmodule

// File: rtl/hier_child_sequencer.sv
// rtl/hier_child_sequencer.sv - launches N children in parallel or in order and reports one done/error to the parent
module hier_child_sequencer
  import hier_seq_pkg::*;
#(
  parameter int NUM_CHILDREN = 5,
  parameter int TIMEOUT_W    = 16,
  parameter int IDX_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic [TIMEOUT_W-1:0]    timeout_i,
  output logic [NUM_CHILDREN-1:0] child_start_o,
  input  logic [NUM_CHILDREN-1:0] child_done_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [NUM_CHILDREN-1:0] done_mask_o,
  output logic [IDX_W-1:0]        fail_idx_o
);

  typedef logic [NUM_CHILDREN-1:0] child_t;
  localparam child_t ONE = child_t'(1);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [IDX_W-1:0]     cur_idx_q, cur_idx_d;
  child_t               start_q, start_d;
  child_t               mask_q, mask_d;
  logic [IDX_W-1:0]     fail_q, fail_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;

  child_t                  cur_sel, done_acc, mask_next;
  logic [MAX_CHILDREN-1:0] padded;
  logic                    phase_done, last_idx;
  logic                    cnt_clr, cnt_en, expired;

  hier_timeout_counter #(.W(TIMEOUT_W)) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .limit_i   (timeout_q),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    timeout_d = timeout_q;
    cur_idx_d = cur_idx_q;
    start_d   = '0;
    mask_d    = mask_q;
    fail_d    = fail_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    // Sequential runs only listen to the child currently in flight.
    cur_sel    = ONE << cur_idx_q;
    done_acc   = (mode_q == MODE_PAR) ? child_done_i : (child_done_i & cur_sel);
    mask_next  = mask_q | done_acc;
    phase_done = (mode_q == MODE_PAR) ? (&mask_next) : (|done_acc);
    last_idx   = (cur_idx_q == IDX_W'(NUM_CHILDREN - 1));
    padded     = '1;
    padded[NUM_CHILDREN-1:0] = mask_next;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          mode_d    = mode_e'(mode_i);
          timeout_d = timeout_i;
          mask_d    = '0;
          fail_d    = '0;
          cur_idx_d = '0;
          busy_d    = 1'b1;
          start_d   = (mode_e'(mode_i) == MODE_SEQ) ? ONE : '1;
          state_d   = LAUNCH;
        end
      end
      LAUNCH, WAIT: begin
        mask_d  = mask_next;
        cnt_clr = (state_q == LAUNCH);
        cnt_en  = (state_q == WAIT);
        // Completion is checked before expiry so a same-cycle race resolves to success.
        if (phase_done) begin
          if ((mode_q == MODE_PAR) || last_idx) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            cur_idx_d = cur_idx_q + IDX_W'(1);
            start_d   = cur_sel << 1;
            state_d   = LAUNCH;
          end
        end else if (expired) begin
          error_d = 1'b1;
          fail_d  = IDX_W'(lowest_zero(padded));
          state_d = ERR;
        end else begin
          state_d = WAIT;
        end
      end
      DONE, ERR: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_PAR;
      timeout_q <= '0;
      cur_idx_q <= '0;
      start_q   <= '0;
      mask_q    <= '0;
      fail_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
      cur_idx_q <= cur_idx_d;
      start_q   <= start_d;
      mask_q    <= mask_d;
      fail_q    <= fail_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign child_start_o = start_q;
  assign done_mask_o   = mask_q;
  assign fail_idx_o    = fail_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_hier_child_sequencer.sv
// tb/tb_hier_child_sequencer.sv - directed scoreboard bench for hier_child_sequencer (N=5)
module tb_hier_child_sequencer;
  import hier_seq_pkg::*;

  localparam int EV_START = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERR   = 2;

  typedef struct {
    int         kind;
    logic [4:0] val;
    int         cyc;
  } ev_t;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        mode_i;
  logic [15:0] timeout_i;
  logic [4:0]  child_start_o;
  logic [4:0]  child_done_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [4:0]  done_mask_o;
  logic [2:0]  fail_idx_o;

  int  n_checks = 0;
  int  n_fails  = 0;
  int  cyc      = 0;
  ev_t exp_q[$];
  int  dly [5];
  int  s;

  hier_child_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .mode_i        (mode_i),
    .timeout_i     (timeout_i),
    .child_start_o (child_start_o),
    .child_done_i  (child_done_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .done_mask_o   (done_mask_o),
    .fail_idx_o    (fail_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input logic [4:0] val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind, input logic [4:0] val);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("event_unexpected", 32'(kind), 32'hffff_ffff);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      check("event_val", 32'(val), 32'(e.val));
      check("event_cycle", 32'(cyc), 32'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (child_start_o != 5'd0) take(EV_START, child_start_o);
    if (done_o)                take(EV_DONE, 5'd0);
    if (error_o)               take(EV_ERR, 5'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offsets are counted from the LAUNCH cycle; children listed in resp answer dly[i] cycles after their own launch.
  task automatic run(input logic mode, input logic [15:0] tmo, input logic [4:0] resp, input int ncyc,
                     input int stray_off, input logic [4:0] stray_val, input int start_off,
                     input int chk_off, input logic [4:0] chk_mask);
    int         due [5];
    logic [4:0] drv;
    for (int i = 0; i < 5; i++) due[i] = -1;
    start_i   = 1'b1;
    mode_i    = mode;
    timeout_i = tmo;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      if (k == chk_off) check("mask_mid_run", 32'(done_mask_o), 32'(chk_mask));
      for (int i = 0; i < 5; i++) begin
        if (child_start_o[i] && resp[i]) due[i] = cyc + dly[i];
      end
      drv = '0;
      for (int i = 0; i < 5; i++) begin
        if (due[i] == cyc) drv[i] = 1'b1;
      end
      if (k == stray_off) drv = drv | stray_val;
      child_done_i = drv;
      start_i = (k == start_off);
      if (k == start_off) begin
        mode_i    = ~mode;
        timeout_i = 16'd3;
      end
      tick();
    end
    child_done_i = '0;
    start_i      = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    mode_i       = 1'b0;
    timeout_i    = '0;
    child_done_i = '0;
    repeat (3) tick();
    check("rst_child_start", 32'(child_start_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_error", 32'(error_o), 32'd0);
    check("rst_mask", 32'(done_mask_o), 32'd0);
    check("rst_fail_idx", 32'(fail_idx_o), 32'd0);
    rst = 1'b0;
    tick();

    // Parallel, staggered completions, no timeout.
    s = cyc;
    push(EV_START, 5'b11111, s + 1);
    push(EV_DONE, 5'd0, s + 9);
    dly = '{3, 1, 7, 2, 4};
    run(1'b0, 16'd0, 5'b11111, 10, -1, 5'd0, -1, 7, 5'b11011);
    check("par_mask", 32'(done_mask_o), 32'h1f);
    check("par_busy_after", 32'(busy_o), 32'd0);

    // Sequential, each child answers 2 cycles after its launch; start clears the previous mask.
    s = cyc;
    for (int i = 0; i < 5; i++) push(EV_START, 5'(1 << i), s + 1 + 3 * i);
    push(EV_DONE, 5'd0, s + 16);
    dly = '{2, 2, 2, 2, 2};
    run(1'b1, 16'd0, 5'b11111, 18, -1, 5'd0, -1, 0, 5'b00000);
    check("seq_mask", 32'(done_mask_o), 32'h1f);

    // Parallel timeout of 10 with children 2 and 4 silent.
    s = cyc;
    push(EV_START, 5'b11111, s + 1);
    push(EV_ERR, 5'd0, s + 12);
    dly = '{2, 5, 9, 3, 9};
    run(1'b0, 16'd10, 5'b01011, 14, -1, 5'd0, -1, 1, 5'b00000);
    check("tmo_fail_idx", 32'(fail_idx_o), 32'd2);
    check("tmo_mask", 32'(done_mask_o), 32'h0b);
    check("tmo_busy_after", 32'(busy_o), 32'd0);

    // Sequential with a stray done on child 3 while child 1 is in flight.
    s = cyc;
    for (int i = 0; i < 5; i++) push(EV_START, 5'(1 << i), s + 1 + 3 * i);
    push(EV_DONE, 5'd0, s + 16);
    dly = '{2, 2, 2, 2, 2};
    run(1'b1, 16'd0, 5'b11111, 18, 4, 5'b01000, -1, 5, 5'b00001);
    check("stray_fail_idx_cleared", 32'(fail_idx_o), 32'd0);
    check("stray_mask", 32'(done_mask_o), 32'h1f);

    // Final done lands in the same cycle the counter reaches 4.
    s = cyc;
    push(EV_START, 5'b11111, s + 1);
    push(EV_DONE, 5'd0, s + 6);
    dly = '{1, 1, 1, 1, 4};
    run(1'b0, 16'd4, 5'b11111, 8, -1, 5'd0, -1, 4, 5'b01111);
    check("race_mask", 32'(done_mask_o), 32'h1f);

    // Reset in the middle of WAIT.
    s = cyc;
    push(EV_START, 5'b11111, s + 1);
    start_i   = 1'b1;
    mode_i    = 1'b0;
    timeout_i = 16'd0;
    tick();
    start_i = 1'b0;
    tick();
    child_done_i = 5'b00001;
    tick();
    child_done_i = '0;
    tick();
    check("pre_rst_mask", 32'(done_mask_o), 32'h01);
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_mask", 32'(done_mask_o), 32'd0);
    check("mid_rst_outs", {27'd0, child_start_o, done_o, error_o}, 32'd0);
    rst = 1'b0;
    tick();

    // Sequential run with a start pulse while busy, which must be ignored.
    s = cyc;
    for (int i = 0; i < 5; i++) push(EV_START, 5'(1 << i), s + 1 + 3 * i);
    push(EV_DONE, 5'd0, s + 16);
    dly = '{2, 2, 2, 2, 2};
    run(1'b1, 16'd0, 5'b11111, 18, -1, 5'd0, 5, 9, 5'b00111);
    repeat (3) tick();
    check("idle_mask_held", 32'(done_mask_o), 32'h1f);
    check("idle_busy", 32'(busy_o), 32'd0);

    // Minimum latency: every child completes during LAUNCH.
    s = cyc;
    push(EV_START, 5'b11111, s + 1);
    push(EV_DONE, 5'd0, s + 2);
    dly = '{0, 0, 0, 0, 0};
    run(1'b0, 16'd0, 5'b11111, 4, -1, 5'd0, -1, 0, 5'b00000);
    check("minlat_mask", 32'(done_mask_o), 32'h1f);

    repeat (3) tick();
    check("events_pending", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/hier_child_sequencer.md
Name: hier_child_sequencer

Overview:
- Parametrised hierarchy node that owns NUM_CHILDREN child instances and drives their start/done handshakes.
- Replaces fixed five-child, portless tree nodes with a node that has a real control interface.
- Launches children in parallel or one after another, collects completions, and aggregates one done/error result for its parent.
- Nodes chain recursively: a parent's child_start_o/child_done_i bits connect to child nodes' start_i/done_o.

Parameters:
- NUM_CHILDREN, 5, number of child handshake channels (1..32).
- TIMEOUT_W, 16, width of the timeout counter and timeout_i.
- IDX_W, $clog2(NUM_CHILDREN) (minimum 1), width of the child index fields.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request pulse from parent; sampled only in IDLE.
- mode_i  in  1  0 = parallel, 1 = sequential; latched with start_i.
- timeout_i  in  TIMEOUT_W  per-phase cycle limit; 0 disables timeout; latched with start_i.
- child_start_o  out  NUM_CHILDREN  one-cycle launch pulse per child.
- child_done_i  in  NUM_CHILDREN  one-cycle completion pulse per child.
- busy_o  out  1  high from the cycle after start is accepted until return to IDLE.
- done_o  out  1  one-cycle success pulse.
- error_o  out  1  one-cycle timeout pulse.
- done_mask_o  out  NUM_CHILDREN  sticky record of children completed in the current run.
- fail_idx_o  out  IDX_W  lowest child not done at timeout; held until the next accepted start.

Behaviour:
- Reset values: all outputs 0; state IDLE; cur_idx 0; counter 0. Reset mid-run aborts immediately, with no done or error pulse.
- States: IDLE, LAUNCH, WAIT, DONE, ERR. All outputs are registered.
- IDLE:
  - start_i high at edge k latches mode and timeout, clears done_mask_o and fail_idx_o, sets cur_idx = 0, and moves to LAUNCH.
  - busy_o = 1 from cycle k+1.
  - start_i in any other state is ignored.
- LAUNCH (one cycle):
  - Parallel: child_start_o = all ones.
  - Sequential: child_start_o = one-hot(cur_idx).
  - Phase counter is cleared. Next state is WAIT.
- Done sampling:
  - child_done_i is sampled in both LAUNCH and WAIT.
  - Parallel: any set bit ORs into done_mask_o.
  - Sequential: only bit cur_idx is accepted; all other bits are ignored and not recorded.
  - Duplicate done pulses are harmless.
- WAIT, parallel: when the mask, including this cycle's done pulses, is all ones, go to DONE.
- WAIT, sequential:
  - When child_done_i[cur_idx] arrives and cur_idx == NUM_CHILDREN-1, go to DONE.
  - Otherwise increment cur_idx and go to LAUNCH.
- Timeout:
  - The counter increments every WAIT cycle and saturates.
  - If timeout_i != 0 and the counter reaches timeout_i with the phase incomplete, go to ERR.
  - fail_idx_o = lowest zero bit of done_mask_o.
  - If completion and expiry occur in the same cycle, completion wins.
- DONE: done_o = 1 for one cycle; busy_o stays 1; next state IDLE.
- ERR: error_o = 1 for one cycle; busy_o stays 1; next state IDLE.
- done_mask_o holds its value in IDLE until the next accepted start.
- Minimum parallel latency: start accepted at k, LAUNCH at k+1, all dones in that same cycle, DONE (done_o) at k+2, IDLE at k+3.
- NUM_CHILDREN = 1: the two modes behave identically.

Decomposition:
- Package hier_seq_pkg holds:
  - the state enum {IDLE, LAUNCH, WAIT, DONE, ERR};
  - the mode enum {MODE_PAR, MODE_SEQ};
  - a function returning the lowest zero bit index of a vector.
- Sub-module hier_timeout_counter contains the saturating counter with clear, enable, limit and zero-disables rule, and outputs expired.
- Everything else is inline in hier_child_sequencer.

Test Plan:
- Parallel, N = 5, timeout 0: start; children done at +3, +1, +7, +2, +4 cycles after LAUNCH.
  - Expect child_start_o = 5'b11111 for exactly one cycle.
  - Expect done_o one cycle after the +7 done, and done_mask_o = 5'b11111.
- Sequential, N = 5: each child answers 2 cycles after its launch.
  - Expect child_start_o pulses 00001, 00010, 00100, 01000, 10000 in order.
  - Expect done_o after child 4, and no overlapping launches.
- Timeout, parallel, timeout_i = 10: children 0, 1 and 3 answer; 2 and 4 never do.
  - Expect error_o 10 WAIT cycles after LAUNCH, fail_idx_o = 2, done_mask_o = 5'b01011, and done_o never asserted.
- Sequential, stray done: pulse child_done_i[3] while cur_idx = 1.
  - Expect the pulse to be ignored (mask bit 3 stays 0) and the sequence to continue normally.
- Same-cycle race: final done arrives in the exact cycle the counter hits timeout_i = 4.
  - Expect done_o = 1 and error_o = 0.
- Reset and restart: rst asserted mid-WAIT.
  - Next cycle: all outputs 0 and state IDLE.
  - A start_i during busy in a later run is ignored.
  - A new start after IDLE runs cleanly with a cleared mask.
